power_averager: RTL and testbench



---
 rtl/power_averager.sv | 170 +++++++++++++++++
 tb/tb_power_averager.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/power_averager.sv
// Mean I^2+Q^2 power over a 2^LOG2_N sample window, with a full-scale clip flag.
// Build option: define POWER_AVG_PEAK_EN to add the per-window peak power output.
module power_averager #(
  parameter int LOG2_N = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_i,
  input  logic [15:0] q_i,
  input  logic        valid_i,
  input  logic        clear_i,
  output logic [31:0] power_o,
  output logic        clip_o,
  output logic        valid_o,
  output logic [31:0] peak_o
);

  localparam int ACC_W = 32 + LOG2_N;

  // S1: squares and per-sample clip detect
  logic signed [30:0] i_ext, q_ext;
  logic [30:0] sq_i_d, sq_q_d, sq_i_q, sq_q_q;
  logic        s1_clip_d, s1_clip_q, s1_valid_d, s1_valid_q;

  // Squares never exceed 2^30, so the low 31 bits of the signed product are exact.
  assign i_ext  = {{15{i_i[15]}}, i_i};
  assign q_ext  = {{15{q_i[15]}}, q_i};
  assign sq_i_d = i_ext * i_ext;
  assign sq_q_d = q_ext * q_ext;
  assign s1_clip_d = (i_i == 16'h8000) || (i_i == 16'h7FFF) ||
                     (q_i == 16'h8000) || (q_i == 16'h7FFF);
  assign s1_valid_d = valid_i && !clear_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_i_q     <= '0;
      sq_q_q     <= '0;
      s1_clip_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else begin
      sq_i_q     <= sq_i_d;
      sq_q_q     <= sq_q_d;
      s1_clip_q  <= s1_clip_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  // S2: per-sample power
  logic [31:0] p_d, p_q;
  logic        s2_clip_q, s2_valid_d, s2_valid_q;

  assign p_d        = {1'b0, sq_i_q} + {1'b0, sq_q_q};
  assign s2_valid_d = s1_valid_q && !clear_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q        <= '0;
      s2_clip_q  <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      p_q        <= p_d;
      s2_clip_q  <= s1_clip_q;
      s2_valid_q <= s2_valid_d;
    end
  end

  // S3: window accumulation
  logic             last_w;
  logic             win_end;
  logic [ACC_W-1:0] sum_w, acc_d, acc_q;
  logic             sticky_d, sticky_q;
  logic [31:0]      power_d, power_q;
  logic             clip_d, clip_q;
  logic             valid_d, valid_q;

  generate
    if (LOG2_N > 0) begin : g_cnt
      logic [LOG2_N-1:0] cnt_d, cnt_q;

      always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
          cnt_d = '0;
        else if (s2_valid_q)
          cnt_d = cnt_q + 1'b1;
      end

      assign last_w = &cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          cnt_q <= '0;
        else
          cnt_q <= cnt_d;
      end
    end else begin : g_no_cnt
      assign last_w = 1'b1;
    end
  endgenerate

  assign win_end = s2_valid_q && last_w && !clear_i;
  assign sum_w   = acc_q + ACC_W'(p_q);

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (clear_i) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end else if (s2_valid_q) begin
      acc_d    = last_w ? '0 : sum_w;
      sticky_d = last_w ? 1'b0 : (sticky_q | s2_clip_q);
    end
  end

  assign power_d = win_end ? sum_w[LOG2_N +: 32] : power_q;
  assign clip_d  = win_end ? (sticky_q | s2_clip_q) : clip_q;
  assign valid_d = win_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
      power_q  <= '0;
      clip_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      power_q  <= power_d;
      clip_q   <= clip_d;
      valid_q  <= valid_d;
    end
  end

  assign power_o = power_q;
  assign clip_o  = clip_q;
  assign valid_o = valid_q;

`ifdef POWER_AVG_PEAK_EN
  logic [31:0] peak_max, peak_d, peak_q, peak_out_d, peak_out_q;

  assign peak_max = (p_q > peak_q) ? p_q : peak_q;

  always_comb begin
    peak_d = peak_q;
    if (clear_i)
      peak_d = '0;
    else if (s2_valid_q)
      peak_d = last_w ? '0 : peak_max;
  end

  assign peak_out_d = win_end ? peak_max : peak_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q     <= '0;
      peak_out_q <= '0;
    end else begin
      peak_q     <= peak_d;
      peak_out_q <= peak_out_d;
    end
  end

  assign peak_o = peak_out_q;
`else
  assign peak_o = '0;
`endif

endmodule

// File: tb/tb_power_averager.sv
// Directed bench for power_averager: one LOG2_N=2 instance and one LOG2_N=0 instance
// on shared stimulus; peak expectations follow POWER_AVG_PEAK_EN.
module tb_power_averager;

`ifdef POWER_AVG_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] i_s, q_s;
  logic        valid_s, clear_s;

  logic [31:0] p2, k2, p0, k0;
  logic        c2, v2, c0, v0;

  always #5 clk = ~clk;

  power_averager #(.LOG2_N(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .i_i(i_s), .q_i(q_s), .valid_i(valid_s),
    .clear_i(clear_s), .power_o(p2), .clip_o(c2), .valid_o(v2), .peak_o(k2)
  );

  power_averager #(.LOG2_N(0)) u_n0 (
    .clk(clk), .rst_n(rst_n), .i_i(i_s), .q_i(q_s), .valid_i(valid_s),
    .clear_i(clear_s), .power_o(p0), .clip_o(c0), .valid_o(v0), .peak_o(k0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Capture every valid_o pulse of the LOG2_N=2 instance, sampled after the edge.
  int          pulses2 = 0;
  logic [31:0] last_p2 = '0;
  logic        last_c2 = 1'b0;
  logic [31:0] last_k2 = '0;

  always @(posedge clk) begin
    #1;
    if (v2 === 1'b1) begin
      pulses2++;
      last_p2 = p2;
      last_c2 = c2;
      last_k2 = k2;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [15:0] i, input logic [15:0] q);
    i_s     = i;
    q_s     = q;
    valid_s = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    i_s     = '0;
    q_s     = '0;
    valid_s = 1'b0;
    clear_s = 1'b0;
    tick(3);
    check("rst_power2", p2, 32'd0);
    check("rst_clip2",  {31'd0, c2}, 32'd0);
    check("rst_valid2", {31'd0, v2}, 32'd0);
    check("rst_peak2",  k2, 32'd0);
    check("rst_power0", p0, 32'd0);
    check("rst_valid0", {31'd0, v0}, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Back-to-back window, latency: valid in cycle c -> valid_o in cycle c+3
    pulses2 = 0;
    repeat (4) send(16'd100, 16'd0);
    check("t1_lat1", {31'd0, v2}, 32'd0);
    tick(1);
    check("t1_lat2", {31'd0, v2}, 32'd0);
    tick(1);
    check("t1_valid", {31'd0, v2}, 32'd1);
    check("t1_power", p2, 32'd10000);
    check("t1_clip",  {31'd0, c2}, 32'd0);
    check("t1_valid0", {31'd0, v0}, 32'd1);
    check("t1_power0", p0, 32'd10000);
    tick(1);
    check("t1_pulse_end", {31'd0, v2}, 32'd0);
    tick(3);
    check("t1_pulses", pulses2, 1);

    // Gapped window
    pulses2 = 0;
    send(16'd3, 16'd4);
    tick(2);
    send(16'd0, 16'd0);
    tick(1);
    send(-16'sd5, 16'd12);
    tick(3);
    send(16'd8, -16'sd6);
    tick(6);
    check("t2_pulses", pulses2, 1);
    check("t2_power", last_p2, 32'd73);
    check("t2_clip", {31'd0, last_c2}, 32'd0);

    // LOG2_N=0 pass-through with full-scale negative sample
    send(16'h8000, 16'h8000);
    check("t3_lat1", {31'd0, v0}, 32'd0);
    tick(1);
    check("t3_lat2", {31'd0, v0}, 32'd0);
    tick(1);
    check("t3_valid0", {31'd0, v0}, 32'd1);
    check("t3_power0", p0, 32'h8000_0000);
    check("t3_clip0", {31'd0, c0}, 32'd1);
    tick(1);
    check("t3_pulse_end0", {31'd0, v0}, 32'd0);
    pulses2 = 0;
    clear_s = 1'b1;
    tick(1);
    clear_s = 1'b0;
    tick(4);
    check("t3_hold_power2", p2, 32'd73);
    check("t3_no_pulse2", pulses2, 0);

    // Partial window, clear, then full window
    pulses2 = 0;
    repeat (3) send(16'd1, 16'd1);
    clear_s = 1'b1;
    tick(1);
    clear_s = 1'b0;
    repeat (4) send(16'd200, 16'd0);
    tick(6);
    check("t4_pulses", pulses2, 1);
    check("t4_power", last_p2, 32'd40000);

    // Clear with the 4th sample itself: sample dropped, window discarded
    pulses2 = 0;
    repeat (3) send(16'd50, 16'd0);
    i_s     = 16'd50;
    q_s     = 16'd0;
    valid_s = 1'b1;
    clear_s = 1'b1;
    tick(1);
    valid_s = 1'b0;
    clear_s = 1'b0;
    tick(6);
    check("t5a_pulses", pulses2, 0);
    check("t5a_hold_power", p2, 32'd40000);

    // Clear in the cycle the 4th sample completes the window in S2
    repeat (4) send(16'd50, 16'd0);
    tick(1);
    clear_s = 1'b1;
    tick(1);
    clear_s = 1'b0;
    tick(5);
    check("t5b_pulses", pulses2, 0);
    repeat (4) send(16'd10, 16'd0);
    tick(6);
    check("t5c_pulses", pulses2, 1);
    check("t5c_power", last_p2, 32'd100);

    // Reset mid-window
    pulses2 = 0;
    repeat (2) send(16'd7, 16'd7);
    rst_n = 1'b0;
    tick(1);
    check("t6_rst_power", p2, 32'd0);
    check("t6_rst_valid", {31'd0, v2}, 32'd0);
    check("t6_rst_clip",  {31'd0, c2}, 32'd0);
    check("t6_rst_peak",  k2, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    repeat (4) send(16'd10, 16'd10);
    tick(6);
    check("t6_pulses", pulses2, 1);
    check("t6_power", last_p2, 32'd200);

    // Clip flag from +full-scale: 32767^2 >> 2
    pulses2 = 0;
    send(16'h7FFF, 16'd0);
    repeat (3) send(16'd0, 16'd0);
    tick(6);
    check("t7_pulses", pulses2, 1);
    check("t7_power", last_p2, 32'd268419072);
    check("t7_clip", {31'd0, last_c2}, 32'd1);

    // Peak tracking, and sticky clip restarts per window
    pulses2 = 0;
    send(16'd1, 16'd0);
    send(16'd30, 16'd40);
    send(16'd2, 16'd0);
    send(16'd0, 16'd3);
    tick(6);
    check("t8_pulses", pulses2, 1);
    check("t8_power", last_p2, 32'd628);
    check("t8_clip", {31'd0, last_c2}, 32'd0);
    check("t8_peak", last_k2, PEAK_EN ? 32'd2500 : 32'd0);
    repeat (4) send(16'd1, 16'd1);
    tick(6);
    check("t8b_pulses", pulses2, 2);
    check("t8b_power", last_p2, 32'd2);
    check("t8b_peak", last_k2, PEAK_EN ? 32'd2 : 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
